// File: rtl/sc_debounce_pkg.sv
// Shared constants and state encoding for the KEY debounce / transition-pulse stage.
// Default timing constants assume CLOCK_50 (20 ns period).
package sc_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // 10 ms debounce window and 250 ms auto-repeat period at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_DEBOUNCE_WIDTH  = 20;
  localparam int DEFAULT_REPEAT_CYCLES   = 12500000;
  localparam int DEFAULT_REPEAT_WIDTH    = 24;

  function automatic logic state_is_down(input db_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sc_debounce_transition0_sync2.sv
// sc_sync2: two-flop synchronizer for raw KEY inputs; resets to the released
// level so a reset never looks like a press.
module sc_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sc_debounce_transition0.sv
// KEY conditioning: synchronize, debounce, and emit one active-low pulse per press.
// Optional held-key auto-repeat is enabled by defining SC_DEBOUNCE_AUTOREPEAT_EN.
module sc_debounce_transition0
  import sc_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DEBOUNCE_WIDTH  = DEFAULT_DEBOUNCE_WIDTH,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter int REPEAT_WIDTH    = DEFAULT_REPEAT_WIDTH
) (
  input  logic       SC_DEBOUNCETRANSITION0_CLOCK_50,
  input  logic       SC_DEBOUNCETRANSITION0_RESET_InHigh,
  input  logic       SC_DEBOUNCETRANSITION0_button_InLow,
  output logic       SC_DEBOUNCETRANSITION0_pulse_OutLow,
  output logic       SC_DEBOUNCETRANSITION0_level_OutLow,
  output logic [1:0] SC_DEBOUNCETRANSITION0_state_Out
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    $error("sc_debounce_transition0: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'd1 << DEBOUNCE_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce_width
    $error("sc_debounce_transition0: DEBOUNCE_WIDTH too small for DEBOUNCE_CYCLES");
  end
  if ((REPEAT_CYCLES < 2) || ((64'd1 << REPEAT_WIDTH) <= 64'(REPEAT_CYCLES))) begin : g_bad_repeat
    $error("sc_debounce_transition0: REPEAT_CYCLES/REPEAT_WIDTH inconsistent");
  end

  localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic clk;
  logic rst;
  logic sync;

  assign clk = SC_DEBOUNCETRANSITION0_CLOCK_50;
  assign rst = SC_DEBOUNCETRANSITION0_RESET_InHigh;

  sc_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (SC_DEBOUNCETRANSITION0_button_InLow),
    .q_o   (sync)
  );

  db_state_e                 state_q, state_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      fire_q, fire_d;
  logic                      press_fire;
  logic                      rep_fire;
  logic                      pulse_q, pulse_d;
  logic                      level_q, level_d;

  // fire_q marks the decision edge; the output flops follow one edge later so
  // pulse and level appear together, DEBOUNCE_CYCLES+3 edges after the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      pulse_q <= 1'b1;
      level_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    press_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          press_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (sync) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        // a bounce back to low re-enters PRESSED without a new pulse
        if (!sync) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SC_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [REPEAT_WIDTH-1:0] RP_LAST = REPEAT_WIDTH'(REPEAT_CYCLES - 1);

  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  // Counts only while staying in PRESSED; any exit clears it so re-entry restarts at 0.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if ((state_q == PRESSED) && !sync) begin
      if (rep_q == RP_LAST) rep_fire = 1'b1;
      else                  rep_d    = rep_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign fire_d = press_fire | rep_fire;

  always_comb begin
    pulse_d = ~fire_q;
    level_d = ~state_is_down(state_q);
  end

  assign SC_DEBOUNCETRANSITION0_pulse_OutLow = pulse_q;
  assign SC_DEBOUNCETRANSITION0_level_OutLow = level_q;
  assign SC_DEBOUNCETRANSITION0_state_Out    = state_q;

endmodule

// File: tb/tb_sc_debounce_transition0.sv
// Self-checking bench for sc_debounce_transition0 with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Expected pulse edges follow the DEBOUNCE_CYCLES+3 latency rule; repeat pulses are expected only with SC_DEBOUNCE_AUTOREPEAT_EN.
module tb_sc_debounce_transition0;

  localparam int DB  = 4;
  localparam int DBW = 3;
  localparam int RP  = 10;
  localparam int RPW = 4;
  localparam int LAT = DB + 3;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       pulse;
  logic       level;
  logic [1:0] state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sc_debounce_transition0 #(
    .DEBOUNCE_CYCLES (DB),
    .DEBOUNCE_WIDTH  (DBW),
    .REPEAT_CYCLES   (RP),
    .REPEAT_WIDTH    (RPW)
  ) dut (
    .SC_DEBOUNCETRANSITION0_CLOCK_50     (clk),
    .SC_DEBOUNCETRANSITION0_RESET_InHigh (rst),
    .SC_DEBOUNCETRANSITION0_button_InLow (btn),
    .SC_DEBOUNCETRANSITION0_pulse_OutLow (pulse),
    .SC_DEBOUNCETRANSITION0_level_OutLow (level),
    .SC_DEBOUNCETRANSITION0_state_Out    (state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          ext_cnt = 0;

  // Record the edge index of every low pulse; downstream counter counts upcount_InLow.
  always @(negedge clk) begin
    if (pulse !== 1'b1) obs_q.push_back(cyc);
  end
  always @(posedge clk) begin
    if (pulse === 1'b0) ext_cnt <= ext_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  // Returns just after edge n (or now if already past it); a change here is first sampled at edge n+1.
  task automatic drive_after(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns on the falling edge following rising edge n.
  task automatic wait_edge(input int unsigned n);
    do @(negedge clk); while (cyc < n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] e, o;
    rst = 1'b1;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (pulse !== 1'b1) begin n_err++; $display("FAIL reset.pulse: got %b want 1", pulse); end
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL reset.level: got %b want 1", level); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset.state: got %0d want 0", state); end
    drive_after(cyc + 1);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL reset.level_idle: got %b want 1", level); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset.state_idle: got %0d want 0", state); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL reset.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_clean_press();
    int unsigned s, r;
    logic [31:0] e, o;
    drive_after(cyc);
    s = cyc + 1;
    btn = 1'b0;
    exp_q.push_back(s + LAT);
    wait_edge(s + LAT - 1);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL clean.level_early: got %b want 1", level); end
    wait_edge(s + LAT);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL clean.level_down: got %b want 0", level); end
    r = s + 12;
    drive_after(r - 1);
    btn = 1'b1;
    wait_edge(r + LAT - 1);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL clean.level_release_early: got %b want 0", level); end
    wait_edge(r + LAT);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL clean.level_up: got %b want 1", level); end
    wait_edge(r + LAT + 4);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL clean.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_press_bounce();
    int unsigned s, s2;
    logic [31:0] e, o;
    drive_after(cyc);
    s = cyc + 1;
    btn = 1'b0;               // low for s, s+1, s+2
    drive_after(s + 2); btn = 1'b1;
    drive_after(s + 3); btn = 1'b0;  // low for s+4, s+5
    drive_after(s + 5); btn = 1'b1;
    for (int i = 6; i <= 16; i++) begin
      wait_edge(s + i);
      n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL press_bounce.level@%0d: got %b want 1", i, level); end
    end
    s2 = cyc + 1;
    btn = 1'b0;
    exp_q.push_back(s2 + LAT);
    drive_after(s2 + 9); btn = 1'b1;
    wait_edge(s2 + 22);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL press_bounce.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_release_bounce();
    int unsigned s;
    logic [31:0] e, o;
    drive_after(cyc);
    s = cyc + 1;
    btn = 1'b0;
    exp_q.push_back(s + LAT);
    drive_after(s + 8); btn = 1'b1;   // glitch high sampled at s+9, s+10
    drive_after(s + 10); btn = 1'b0;
    for (int i = 7; i <= 14; i++) begin
      wait_edge(s + i);
      n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL release_bounce.level@%0d: got %b want 0", i, level); end
    end
    drive_after(s + 14); btn = 1'b1;  // real release sampled at s+15
    for (int i = 15; i <= 21; i++) begin
      wait_edge(s + i);
      n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL release_bounce.level@%0d: got %b want 0", i, level); end
    end
    wait_edge(s + 15 + LAT);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL release_bounce.level_up: got %b want 1", level); end
    wait_edge(s + 27);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL release_bounce.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned s, k;
    logic [31:0] e, o;
    drive_after(cyc);
    s = cyc + 1;
    btn = 1'b0;
    drive_after(s + 4);       // FSM is in PRESS_WAIT here
    rst = 1'b1;
    #1;
    n_cmp++; if (pulse !== 1'b1) begin n_err++; $display("FAIL reset_mid.pulse: got %b want 1", pulse); end
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL reset_mid.level: got %b want 1", level); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_mid.state: got %0d want 0", state); end
    k = s + 6;
    drive_after(k);
    rst = 1'b0;               // button still held; first sample at k+1
    exp_q.push_back(k + 1 + LAT);
    wait_edge(k + LAT);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL reset_mid.level_early: got %b want 1", level); end
    wait_edge(k + 1 + LAT);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL reset_mid.level_down: got %b want 0", level); end
    drive_after(k + 10); btn = 1'b1;
    wait_edge(k + 22);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL reset_mid.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned s;
    int          start;
    logic [31:0] e, o;
    start = ext_cnt;
    for (int p = 0; p < 3; p++) begin
      drive_after(cyc);
      s = cyc + 1;
      btn = 1'b0;
      exp_q.push_back(s + LAT);
      drive_after(s + 8 + $urandom_range(0, 2)); btn = 1'b1;
      wait_edge(s + 22);
    end
    n_cmp++; if (ext_cnt - start !== 3) begin n_err++; $display("FAIL chain.count: got %0d want 3", ext_cnt - start); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL chain.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_hold();
    int unsigned s;
    logic [31:0] e, o;
    drive_after(cyc);
    s = cyc + 1;
    btn = 1'b0;
    exp_q.push_back(s + LAT);
`ifdef SC_DEBOUNCE_AUTOREPEAT_EN
    exp_q.push_back(s + LAT + RP);
    exp_q.push_back(s + LAT + 2 * RP);
    exp_q.push_back(s + LAT + 3 * RP);
`endif
    drive_after(s + 39); btn = 1'b1;  // held for 40 samples
    wait_edge(s + 38);
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL hold.level: got %b want 0", level); end
    wait_edge(s + 55);
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL hold.level_after: got %b want 1", level); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : NONE;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL hold.pulse_edge: got %0d want %0d", o, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid();
    test_back_to_back();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 10000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
